// File: rtl/sr_excite_driver.sv
// Handshake-driven s/r excitation for one external SR flip-flop, with q/q1 feedback check.
// Latency: done at acceptance+PULSE_CYCLES+1 (transition) or +1 (no change); tgt_ready only in IDLE.
module sr_excite_driver #(
  parameter int PULSE_CYCLES = 1,
  parameter int TIMEOUT      = 4,
  parameter int ERR_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  input  logic             tgt_bit,
  output logic             tgt_ready,
  output logic             s,
  output logic             r,
  input  logic             q_in,
  input  logic             q1_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  localparam int PW = $clog2(PULSE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES);
  localparam logic [TW-1:0] WAIT_LAST  = TW'(TIMEOUT - 1);

  logic [1:0]    state;
  logic          tgt;
  logic [PW-1:0] pulse_cnt;
  logic [TW-1:0] wait_cnt;
  logic          q_match;
  logic          done_evt;
  logic          err_evt;

  assign tgt_ready = (state == IDLE) && !rst;
  assign busy      = (state != IDLE);

  // q reaching the target ends WAIT either way; a non-complementary q1 at that point is an error.
  always_comb begin
    q_match  = (q_in == tgt);
    done_evt = 1'b0;
    err_evt  = 1'b0;
    if (state == WAIT) begin
      if (q_match) begin
        done_evt = (q1_in != tgt);
        err_evt  = (q1_in == tgt);
      end else begin
        err_evt  = (wait_cnt == WAIT_LAST);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tgt       <= 1'b0;
      s         <= 1'b0;
      r         <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= '0;
      pulse_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      done <= done_evt;
      err  <= err_evt;
      if (err_evt && (err_cnt != {ERR_W{1'b1}}))
        err_cnt <= err_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (tgt_valid) begin
            tgt      <= tgt_bit;
            wait_cnt <= '0;
            if (q_in != tgt_bit) begin
              s         <= tgt_bit;
              r         <= !tgt_bit;
              pulse_cnt <= PW'(1);
              state     <= DRIVE;
            end else begin
              s     <= 1'b0;
              r     <= 1'b0;
              state <= WAIT;
            end
          end
        end
        DRIVE: begin
          if (pulse_cnt == PULSE_LAST) begin
            s        <= 1'b0;
            r        <= 1'b0;
            wait_cnt <= '0;
            state    <= WAIT;
          end else begin
            pulse_cnt <= pulse_cnt + 1'b1;
          end
        end
        WAIT: begin
          if (done_evt || err_evt)
            state <= IDLE;
          else
            wait_cnt <= wait_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_excite_driver.sv
// Directed bench: table of transactions against an ideal srff model, plus reset and saturation sequences.
module tb_sr_excite_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, tgt_valid, tgt_bit, tgt_ready, s, r, busy, done, err;
  logic       q, q1, stuck, bad;
  logic [7:0] err_cnt;

  logic       rst3, v3, b3, rdy3, s3, r3, busy3, done3, err3, q3;
  logic [7:0] cnt3;

  int checks = 0;
  int failures = 0;

  sr_excite_driver dut (
    .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit), .tgt_ready(tgt_ready),
    .s(s), .r(r), .q_in(q), .q1_in(q1), .busy(busy), .done(done), .err(err), .err_cnt(err_cnt)
  );

  sr_excite_driver #(.PULSE_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst3), .tgt_valid(v3), .tgt_bit(b3), .tgt_ready(rdy3),
    .s(s3), .r(r3), .q_in(q3), .q1_in(~q3), .busy(busy3), .done(done3), .err(err3), .err_cnt(cnt3)
  );

  // Ideal srff: q follows s/r on the edge that samples them.
  initial begin q = 1'b0; q3 = 1'b0; end
  always @(posedge clk) begin
    if (!stuck) begin
      if (s) q <= 1'b1;
      else if (r) q <= 1'b0;
    end
    if (s3) q3 <= 1'b1;
    else if (r3) q3 <= 1'b0;
  end
  assign q1 = bad ? q : ~q;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where done/err is seen.
  task automatic send(input logic tb, input int exp_lat, input logic exp_dn, input logic exp_er,
                      input int exp_s, input int exp_r, input int exp_cnt, input string nm);
    int lat = -1;
    int sc = 0;
    int rc = 0;
    int both = 0;
    logic gd = 1'b0;
    logic ge = 1'b0;
    tgt_valid = 1'b1;
    tgt_bit   = tb;
    chk({nm, ".ready"}, 32'(tgt_ready), 1);
    @(posedge clk); @(negedge clk);
    tgt_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (s) sc++;
      if (r) rc++;
      if (s && r) both++;
      if (done || err) begin
        lat = k; gd = done; ge = err;
        break;
      end
      @(posedge clk); @(negedge clk);
    end
    chk({nm, ".lat"}, 32'(lat), 32'(exp_lat));
    chk({nm, ".done"}, 32'(gd), 32'(exp_dn));
    chk({nm, ".err"}, 32'(ge), 32'(exp_er));
    chk({nm, ".s_cycles"}, 32'(sc), 32'(exp_s));
    chk({nm, ".r_cycles"}, 32'(rc), 32'(exp_r));
    chk({nm, ".s_and_r"}, 32'(both), 0);
    chk({nm, ".err_cnt"}, 32'(err_cnt), 32'(exp_cnt));
  endtask

  typedef struct {
    logic tgt;
    logic stuck;
    logic bad;
    int   lat;
    logic dn;
    logic er;
    int   sc;
    int   rc;
    int   cnt;
  } vec_t;

  vec_t vt[8];

  initial begin
    vt[0] = '{1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1, 0, 0};  // 0->1 set pulse
    vt[1] = '{1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b0, 0, 1, 0};  // 1->0 reset pulse
    vt[2] = '{1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0, 0, 0, 0};  // back-to-back, no change
    vt[3] = '{1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b1, 0, 0, 1};  // no change, q1 == q
    vt[4] = '{1'b1, 1'b1, 1'b0, 5, 1'b0, 1'b1, 1, 0, 2};  // stuck q: timeout
    vt[5] = '{1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1, 0, 2};
    vt[6] = '{1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b0, 0, 0, 2};
    vt[7] = '{1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b1, 0, 1, 3};  // transition, q1 == q at match

    stuck = 1'b0; bad = 1'b0;
    rst = 1'b1; tgt_valid = 1'b1; tgt_bit = 1'b1;
    rst3 = 1'b1; v3 = 1'b0; b3 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.s", 32'(s), 0);
    chk("rst.r", 32'(r), 0);
    chk("rst.ready", 32'(tgt_ready), 0);
    chk("rst.err_cnt", 32'(err_cnt), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.done_err", 32'(done | err), 0);
    rst = 1'b0; rst3 = 1'b0; tgt_valid = 1'b0;
    #1;
    chk("rel.ready", 32'(tgt_ready), 1);
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      stuck = vt[i].stuck;
      bad   = vt[i].bad;
      send(vt[i].tgt, vt[i].lat, vt[i].dn, vt[i].er, vt[i].sc, vt[i].rc, vt[i].cnt,
           $sformatf("vec%0d", i));
    end
    stuck = 1'b0;

    // q is 0 here; every no-change request with q1 == q is an error.
    bad = 1'b1;
    for (int i = 0; i < 300; i++)
      send(1'b0, 1, 1'b0, 1'b1, 0, 0, (4 + i > 255) ? 255 : 4 + i, $sformatf("sat%0d", i));
    bad = 1'b0;
    chk("sat.final", 32'(err_cnt), 255);

    // Reset in the middle of a 3-cycle set pulse.
    v3 = 1'b1; b3 = 1'b1;
    chk("d3.ready", 32'(rdy3), 1);
    @(posedge clk); @(negedge clk);
    v3 = 1'b0;
    chk("d3.s_drive", 32'(s3), 1);
    @(posedge clk); @(negedge clk);
    chk("d3.busy_drive", 32'(busy3), 1);
    rst3 = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("d3.rst_s", 32'(s3), 0);
    chk("d3.rst_busy", 32'(busy3), 0);
    chk("d3.rst_done_err", 32'(done3 | err3), 0);
    rst3 = 1'b0;
    begin
      int seen = 0;
      for (int k = 0; k < 8; k++) begin
        @(posedge clk); @(negedge clk);
        if (done3 || err3 || s3 || r3) seen++;
      end
      chk("d3.quiet_after_rst", 32'(seen), 0);
    end

    // q3 is now 1: a clear request holds r for 3 cycles, done 4 edges after acceptance.
    begin
      int lat = -1;
      int rc = 0;
      v3 = 1'b1; b3 = 1'b0;
      chk("d3b.ready", 32'(rdy3), 1);
      @(posedge clk); @(negedge clk);
      v3 = 1'b0;
      for (int k = 0; k < 40; k++) begin
        if (r3) rc++;
        if (done3 || err3) begin lat = k; break; end
        @(posedge clk); @(negedge clk);
      end
      chk("d3b.lat", 32'(lat), 4);
      chk("d3b.done", 32'(done3), 1);
      chk("d3b.r_cycles", 32'(rc), 3);
      chk("d3b.err_cnt", 32'(cnt3), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
